// File: rtl/uart_pkg.sv
// Shared definitions for the uart_frame_tx framer: FSM encoding, frame byte
// indices, frame lengths and the captured-field record.
package uart_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_NEXT      = 3'd4;
  localparam logic [2:0] S_FINISH    = 3'd5;

  localparam logic [2:0] IDX_START   = 3'd0;
  localparam logic [2:0] IDX_ADDR    = 3'd1;
  localparam logic [2:0] IDX_CODE    = 3'd2;
  localparam logic [2:0] IDX_DATA_HI = 3'd3;
  localparam logic [2:0] IDX_DATA_LO = 3'd4;
  localparam logic [2:0] IDX_CSUM    = 3'd5;

  localparam logic [2:0] FRAME_LEN_BASE = 3'd5;
  localparam logic [2:0] FRAME_LEN_CSUM = 3'd6;

  typedef struct packed {
    logic [7:0]  addr;
    logic [7:0]  code;
    logic [15:0] data;
  } frame_fields_t;

  function automatic logic [2:0] last_index(input logic csum_en);
    if (csum_en) begin
      last_index = FRAME_LEN_CSUM - 3'd1;
    end else begin
      last_index = FRAME_LEN_BASE - 3'd1;
    end
  endfunction

  // Start byte and checksum are not captured fields; the top supplies them.
  function automatic logic [7:0] field_byte(input frame_fields_t f, input logic [2:0] idx);
    case (idx)
      IDX_ADDR:            field_byte = f.addr;
      IDX_CODE:            field_byte = f.code;
      IDX_DATA_HI:         field_byte = f.data[15:8];
      IDX_DATA_LO:         field_byte = f.data[7:0];
      IDX_START, IDX_CSUM: field_byte = 8'h00;
      default:             field_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/uart_frame_tx_if.sv
// Byte-level handshake between the frame sequencer (master) and a UART
// transmitter (slave).
interface uart_frame_tx_if;
  logic       tx_has_data;
  logic [7:0] tx_data;
  logic       tx_is_transmitting;
  logic       tx_done;

  modport master (
    output tx_has_data,
    output tx_data,
    input  tx_is_transmitting,
    input  tx_done
  );

  modport slave (
    input  tx_has_data,
    input  tx_data,
    output tx_is_transmitting,
    output tx_done
  );
endinterface

// File: rtl/frame_checksum.sv
// Running XOR accumulator over the frame bytes; cleared at the start of each frame.
module frame_checksum (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic [7:0] i_data,
  output logic [7:0] o_sum
);

  logic [7:0] r_sum;

  // Accumulate one byte per enable pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sum <= 8'h00;
    end else if (i_clear) begin
      r_sum <= 8'h00;
    end else if (i_enable) begin
      r_sum <= r_sum ^ i_data;
    end else begin
      r_sum <= r_sum;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/uart_frame_tx.sv
// Sequences a START/addr/code/data-hi/data-lo frame into a byte UART.
// Define UART_FRAME_CHECKSUM_EN to append an XOR checksum byte.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter logic [7:0] START_BYTE = 8'hAA
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            send_request,
  input  logic [7:0]      device_address,
  input  logic [7:0]      response_code,
  input  logic [15:0]     response_data,
  output logic            ready,
  output logic            frame_done,
  uart_frame_tx_if.master tx
);

`ifdef UART_FRAME_CHECKSUM_EN
  localparam logic CSUM_EN = 1'b1;
`else
  localparam logic CSUM_EN = 1'b0;
`endif
  localparam logic [2:0] LAST_IDX = last_index(CSUM_EN);

  logic [2:0]    r_state;
  logic [2:0]    w_next_state;
  logic [2:0]    r_idx;
  frame_fields_t r_fields;
  logic          r_tx_done_prev;
  logic          r_ready;
  logic          r_frame_done;
  logic          r_tx_has_data;
  logic [7:0]    r_tx_data;
  logic          w_accept;
  logic          w_tx_done_rise;
  logic [7:0]    w_byte;

  assign w_accept       = (r_state == S_IDLE) && send_request;
  assign w_tx_done_rise = tx.tx_done && !r_tx_done_prev;

`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0] w_csum;
  logic       w_csum_en;

  assign w_csum_en = (r_state == S_LOAD) && (r_idx >= IDX_ADDR) && (r_idx <= IDX_DATA_LO);

  frame_checksum u_frame_checksum (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_accept),
    .i_enable (w_csum_en),
    .i_data   (w_byte),
    .o_sum    (w_csum)
  );
`endif

  // Next-state logic of the frame sequencer.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = S_LOAD;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_LOAD: w_next_state = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (tx.tx_is_transmitting) begin
          w_next_state = S_WAIT_DONE;
        end else begin
          w_next_state = S_WAIT_BUSY;
        end
      end
      S_WAIT_DONE: begin
        if (w_tx_done_rise) begin
          w_next_state = S_NEXT;
        end else begin
          w_next_state = S_WAIT_DONE;
        end
      end
      S_NEXT: begin
        if (r_idx == LAST_IDX) begin
          w_next_state = S_FINISH;
        end else begin
          w_next_state = S_LOAD;
        end
      end
      S_FINISH: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Byte selected by the current index.
  always_comb begin
    w_byte = 8'h00;
    if (r_idx == IDX_START) begin
      w_byte = START_BYTE;
    end
`ifdef UART_FRAME_CHECKSUM_EN
    else if (r_idx == IDX_CSUM) begin
      w_byte = w_csum;
    end
`endif
    else begin
      w_byte = field_byte(r_fields, r_idx);
    end
  end

  // State, capture, index and registered outputs; ready/frame_done track the
  // next state so they line up exactly with IDLE and FINISH.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_idx          <= IDX_START;
      r_fields       <= '{addr: 8'h00, code: 8'h00, data: 16'h0000};
      r_tx_done_prev <= 1'b0;
      r_ready        <= 1'b1;
      r_frame_done   <= 1'b0;
      r_tx_has_data  <= 1'b0;
      r_tx_data      <= 8'h00;
    end else begin
      r_state        <= w_next_state;
      r_tx_done_prev <= tx.tx_done;
      r_ready        <= (w_next_state == S_IDLE);
      r_frame_done   <= (w_next_state == S_FINISH);
      r_tx_has_data  <= (r_state == S_LOAD);
      if (w_accept) begin
        r_fields <= '{addr: device_address, code: response_code, data: response_data};
        r_idx    <= IDX_START;
      end else if ((r_state == S_NEXT) && (r_idx != LAST_IDX)) begin
        r_idx <= r_idx + 3'd1;
      end else begin
        r_idx <= r_idx;
      end
      if (r_state == S_LOAD) begin
        r_tx_data <= w_byte;
      end else begin
        r_tx_data <= r_tx_data;
      end
    end
  end

  assign ready          = r_ready;
  assign frame_done     = r_frame_done;
  assign tx.tx_has_data = r_tx_has_data;
  assign tx.tx_data     = r_tx_data;

endmodule
